// File: rtl/serializador_paralelo_serial.sv
// Parallel-in/serial-out converter with a valid/ready handshake on the parallel side.
// A frame is WIDTH bits, one per clock, optionally followed by GAP forced idle cycles.
module serializador_paralelo_serial #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2:0]      GAP_LAST = 3'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       gap_q, gap_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);
  assign accept   = data_valid && data_ready;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    data_ready     = 1'b0;
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;

    if (!reset && ((state_q == S_IDLE) || (last_bit && (GAP == 0)))) begin
      data_ready = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          // A same-cycle accept is only possible when GAP is zero (back-to-back frames).
          if (accept) begin
            shreg_d = data_in;
            cnt_d   = '0;
          end else if (GAP > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Serial outputs are registered from the next state so they change only on the clock.
    if (state_d == S_SHIFT) begin
      serial_valid_d = 1'b1;
      serial_out_d   = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = serial_valid_q && (cnt_q == '0);
  assign frame_done   = serial_valid_q && (cnt_q == LAST_BIT);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_serializador_paralelo_serial.sv
// Directed bench for serializador_paralelo_serial: three instances cover MSB/LSB-first order
// and GAP=0/GAP=2; each observation is a packed {ready,busy,valid,out,start,done} vector.
module tb_serializador_paralelo_serial;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] a_din, b_din, c_din;
  logic       a_dv, b_dv, c_dv;
  logic       a_rdy, a_so, a_sv, a_fs, a_fd, a_busy;
  logic       b_rdy, b_so, b_sv, b_fs, b_fd, b_busy;
  logic       c_rdy, c_so, c_sv, c_fs, c_fd, c_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .clock(clock), .reset(reset), .data_in(a_din), .data_valid(a_dv), .data_ready(a_rdy),
    .serial_out(a_so), .serial_valid(a_sv), .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy)
  );

  serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clock(clock), .reset(reset), .data_in(b_din), .data_valid(b_dv), .data_ready(b_rdy),
    .serial_out(b_so), .serial_valid(b_sv), .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy)
  );

  serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u_gap (
    .clock(clock), .reset(reset), .data_in(c_din), .data_valid(c_dv), .data_ready(c_rdy),
    .serial_out(c_so), .serial_valid(c_sv), .frame_start(c_fs), .frame_done(c_fd), .busy(c_busy)
  );

  function automatic logic [5:0] va();
    return {a_rdy, a_busy, a_sv, a_so, a_fs, a_fd};
  endfunction
  function automatic logic [5:0] vb();
    return {b_rdy, b_busy, b_sv, b_so, b_fs, b_fd};
  endfunction
  function automatic logic [5:0] vc();
    return {c_rdy, c_busy, c_sv, c_so, c_fs, c_fd};
  endfunction

  // Expected vector: {ready, busy, valid, out, start, done}
  function automatic logic [5:0] ev(input logic rdy, busy, sv, so, fs, fd);
    return {rdy, busy, sv, so, fs, fd};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [5:0] IDLE_V = 6'b100000;
  localparam logic [5:0] ZERO_V = 6'b000000;
  localparam logic [5:0] GAP_V  = 6'b010000;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;

    reset = 1'b1;
    a_dv = 1'b0; b_dv = 1'b0; c_dv = 1'b0;
    a_din = '0;  b_din = '0;  c_din = '0;

    // Reset state, ready forced low while reset is high
    tick();
    tick();
    check("reset_a", va(), ZERO_V);
    check("reset_b", vb(), ZERO_V);
    check("reset_c", vc(), ZERO_V);
    reset = 1'b0;
    #1;
    check("idle_a", va(), IDLE_V);
    check("idle_b", vb(), IDLE_V);
    check("idle_c", vc(), IDLE_V);

    // 1: MSB first, 4'b1011 -> 1,0,1,1
    w4 = 4'b1011;
    a_din = w4; a_dv = 1'b1;
    tick();
    a_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_bit%0d", i), va(), ev(i == 3, 1'b1, 1'b1, w4[3-i], i == 0, i == 3));
      tick();
    end
    check("t1_idle", va(), IDLE_V);

    // 2: LSB first, 4'b1011 -> 1,1,0,1
    b_din = w4; b_dv = 1'b1;
    tick();
    b_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_bit%0d", i), vb(), ev(i == 3, 1'b1, 1'b1, w4[i], i == 0, i == 3));
      tick();
    end
    check("t2_idle", vb(), IDLE_V);

    // 3: back-to-back A then 5 with valid held, data_in changed after first accept
    w8 = 8'b1010_0101;
    a_din = 4'hA; a_dv = 1'b1;
    tick();
    a_din = 4'h5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) a_dv = 1'b0;
      check($sformatf("t3_bit%0d", i), va(),
            ev(i == 3 || i == 7, 1'b1, 1'b1, w8[7-i], i == 0 || i == 4, i == 3 || i == 7));
      tick();
    end
    check("t3_idle", va(), IDLE_V);

    // 6: word 3 in flight, data_in glitches, then word 6 offered from cycle 2 and held
    w8 = 8'b0011_0110;
    a_din = 4'h3; a_dv = 1'b1;
    tick();
    a_dv = 1'b0; a_din = 4'hC;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin a_dv = 1'b1; a_din = 4'h6; end
      if (i == 4) a_dv = 1'b0;
      check($sformatf("t6_bit%0d", i), va(),
            ev(i == 3 || i == 7, 1'b1, 1'b1, w8[7-i], i == 0 || i == 4, i == 3 || i == 7));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_after%0d", i), va(), IDLE_V);
      tick();
    end

    // 4: GAP=2, two words offered back-to-back
    c_din = 4'hA; c_dv = 1'b1;
    tick();
    c_din = 4'h5;
    w4 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_a_bit%0d", i), vc(), ev(1'b0, 1'b1, 1'b1, w4[3-i], i == 0, i == 3));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t4_gap1_%0d", i), vc(), GAP_V);
      tick();
    end
    check("t4_idle_accept", vc(), IDLE_V);
    tick();
    c_dv = 1'b0;
    w4 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_b_bit%0d", i), vc(), ev(1'b0, 1'b1, 1'b1, w4[3-i], i == 0, i == 3));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t4_gap2_%0d", i), vc(), GAP_V);
      tick();
    end
    check("t4_idle_end", vc(), IDLE_V);

    // 5: reset in cycle 2 of a frame, reset also overriding an accept
    a_din = 4'hF; a_dv = 1'b1;
    tick();
    a_dv = 1'b0;
    check("t5_cycle1", va(), ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tick();
    check("t5_cycle2", va(), ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    check("t5_rdy_in_reset", va(), ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("t5_cycle3", va(), ZERO_V);
    a_din = 4'h9; a_dv = 1'b1;
    tick();
    check("t5_reset_beats_accept", va(), ZERO_V);
    reset = 1'b0; a_dv = 1'b0;
    #1;
    check("t5_ready_after", va(), IDLE_V);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_quiet%0d", i), va(), IDLE_V);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
